sipo_drain_ctrl: RTL and testbench
==================================

# sipo_drain_ctrl

Single-clock AXI4-Lite master that sequences the `sipo` capture block through its register map. It enables the block, polls the status register, and drains captured words from the data register into a valid/ready output stream. It also disables and flushes the block on command. It sits between the `sipo` slave port and the downstream packet consumer, in the `sipo` slave's AXI clock domain.

## Interface
- `BASE_ADDR`, 0: `sipo` register base; registers are DATA +0x00, STATUS +0x08, CTRL +0x10.
- `POLL_GAP`, 16: idle cycles between status polls while the FIFO is empty; legal range 1..65535.
- `m_axi4lite_clk` in 1: the single clock.
- `m_axi4lite_rstn` in 1: reset; synchronous, active-low.
- `start` in 1: one-cycle pulse; leave IDLE/ERR and begin capture.
- `stop` in 1: one-cycle pulse; disable capture, return to IDLE.
- `flush` in 1: one-cycle pulse; pulse the `sipo` user reset, then return to IDLE.
- `out_valid`/`out_data`/`out_ready`: out/out/in, 1/`AXI4_DATA_BITS`/1, drained word stream.
- `busy` out 1: state != IDLE and state != ERR.
- `err` out 1: sticky; set on any non-OKAY response.
- `overflow` out 1: sticky; set when STATUS bit1 (full) is read as 1.
- `word_cnt` out 32: words delivered on the stream; wraps modulo 2^32.
- AW channel: `m_axi4lite_aw_{valid,ready,addr,prot}` — out/in/out/out, `AXI4_ADDR_BITS`/`AXI4_PROT_BITS` widths.
- W channel: `m_axi4lite_w_{valid,ready,data,strb}` — out/in/out/out.
- B channel: `m_axi4lite_b_{valid,ready,resp}` — in/out/in.
- AR channel: `m_axi4lite_ar_{valid,ready,addr,prot}` — out/in/out/out.
- R channel: `m_axi4lite_r_{valid,ready,data,resp}` — in/out/in/in.

## Operation
- Fixed field values: `prot` = 0 and `strb` = all ones at all times.
- Write data uses CTRL bit0 = en and bit1 = user_rstn.
- States: IDLE, WR_REQ, WR_RESP, POLL_REQ, POLL_RESP, GAP, RD_REQ, RD_RESP, PUSH, ERR.
- A write sequence carries a target CTRL value `wval` and a return state `wret`.
- IDLE + `start`: `wval` = 2'b11, `wret` = POLL_REQ, go to WR_REQ.
- ERR + `start`: same as IDLE + `start`, and `err` and `overflow` clear.
- IDLE + `flush`: `wval` = 2'b01 (user_rstn low), `wret` = WR_REQ with `wval` = 2'b10, final `wret` = IDLE.
  - `overflow` clears at flush completion.
- Priority in IDLE: `flush` > `start`.
- `stop` in any busy state:
  - Latched as `stop_pend`; ignored in IDLE/ERR.
  - Honoured only at the next entry to POLL_REQ, GAP or PUSH-completion, so it never abandons an AXI transaction mid-flight.
  - When honoured: write `wval` = 2'b10, `wret` = IDLE.
  - An undelivered PUSH word is delivered first.
- WR_REQ:
  - Assert `aw_valid` (addr BASE+0x10) and `w_valid` (data `wval`) together.
  - Each channel deasserts independently after its own handshake.
  - Go to WR_RESP once both are done.
- WR_RESP: `b_ready` = 1.
  - On `b_valid`: resp OKAY → `wret`; otherwise → ERR.
- POLL_REQ: `ar_valid`, addr BASE+0x08; on `ar_ready` → POLL_RESP.
- POLL_RESP: `r_ready` = 1.
  - On `r_valid`: non-OKAY → ERR.
  - Bit1 = 1 → set `overflow`.
  - Bit0 = 1 (empty) → GAP; else → RD_REQ.
- GAP: count `POLL_GAP` cycles, then POLL_REQ.
- RD_REQ/RD_RESP: same as POLL_REQ/POLL_RESP with addr BASE+0x00.
  - On OKAY, capture `r_data` to `out_data` → PUSH; non-OKAY → ERR.
- PUSH: `out_valid` = 1 with `out_data` held stable.
  - On `out_ready`: increment `word_cnt`, then POLL_REQ (or the stop write).
- Every data read is preceded by a status read showing non-empty, because DATA returns 0 when empty.
- ERR: all AXI valids low; `busy` = 0; wait for `start`.

## Timing
- Reset (`m_axi4lite_rstn` = 0 at a clock edge) forces the following:
  - state IDLE;
  - all `*_valid`/`*_ready` outputs 0;
  - addr/data outputs 0;
  - `out_data` 0, `word_cnt` 0;
  - `err`, `overflow`, `busy`, `stop_pend` 0.
- Reset mid-transaction drops valids immediately, with no completion; the slave is reset by the same domain.
- All outputs are registered.
- Valids rise the cycle after state entry and never drop before their handshake.
- `addr`/`data` are stable while valid.
- Minimum word cadence, with ready=1 everywhere: POLL_REQ 1, POLL_RESP ≥1, RD_REQ 1, RD_RESP ≥1, PUSH 1, giving 5 cycles per word.
- `b_ready` is asserted only in WR_RESP; `r_ready` only in POLL_RESP/RD_RESP.
- `start`/`flush` pulses in busy states are ignored. `stop` together with `start` in IDLE: `start` wins, `stop` is dropped.
- `word_cnt` increments on the PUSH handshake cycle; 0xFFFFFFFF+1 → 0 with no flag.

## Test plan
- `start`, slave with 3 words (0xA1, 0xB2, 0xC3), ready always high:
  - Expect CTRL write of 0x3.
  - Expect status/data read pairs and the stream 0xA1, 0xB2, 0xC3.
  - Expect `word_cnt` = 3, then GAP polls every `POLL_GAP`+2 cycles.
- Back-pressure: hold `out_ready` = 0 for 20 cycles in PUSH.
  - `out_data` stays stable and no new AR is issued.
  - The word is delivered once when released.
- `stop` asserted during RD_RESP with `r_valid` delayed 5 cycles:
  - The read completes and the word is pushed.
  - Then a CTRL write of 0x2 occurs, then IDLE with `busy` = 0.
- `flush` in IDLE after the status read showed full:
  - CTRL writes 0x1 then 0x2 occur in order.
  - `overflow` is 1 before and 0 after.
- SLVERR on the data read:
  - ERR state, `err` = 1, no stream output.
  - A subsequent `start` clears `err` and rewrites CTRL 0x3.
- Reset asserted while `aw_valid`=1 and `aw_ready`=0:
  - Next cycle all valids are 0, state IDLE, `word_cnt` = 0.

Source files
------------

// File: rtl/sipo_drain_ctrl.sv
// rtl/sipo_drain_ctrl.sv - AXI4-Lite master that enables, polls and drains the sipo capture block
module sipo_drain_ctrl #(
    parameter int AXI4_ADDR_BITS = 32,
    parameter int AXI4_DATA_BITS = 32,
    parameter int AXI4_PROT_BITS = 3,
    parameter logic [AXI4_ADDR_BITS-1:0] BASE_ADDR = '0,
    parameter int POLL_GAP = 16
) (
    input  logic                        m_axi4lite_clk,
    input  logic                        m_axi4lite_rstn,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [AXI4_DATA_BITS-1:0]   out_data,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err,
    output logic                        overflow,
    output logic [31:0]                 word_cnt,
    output logic                        m_axi4lite_aw_valid,
    input  logic                        m_axi4lite_aw_ready,
    output logic [AXI4_ADDR_BITS-1:0]   m_axi4lite_aw_addr,
    output logic [AXI4_PROT_BITS-1:0]   m_axi4lite_aw_prot,
    output logic                        m_axi4lite_w_valid,
    input  logic                        m_axi4lite_w_ready,
    output logic [AXI4_DATA_BITS-1:0]   m_axi4lite_w_data,
    output logic [AXI4_DATA_BITS/8-1:0] m_axi4lite_w_strb,
    input  logic                        m_axi4lite_b_valid,
    output logic                        m_axi4lite_b_ready,
    input  logic [1:0]                  m_axi4lite_b_resp,
    output logic                        m_axi4lite_ar_valid,
    input  logic                        m_axi4lite_ar_ready,
    output logic [AXI4_ADDR_BITS-1:0]   m_axi4lite_ar_addr,
    output logic [AXI4_PROT_BITS-1:0]   m_axi4lite_ar_prot,
    input  logic                        m_axi4lite_r_valid,
    output logic                        m_axi4lite_r_ready,
    input  logic [AXI4_DATA_BITS-1:0]   m_axi4lite_r_data,
    input  logic [1:0]                  m_axi4lite_r_resp
);
    localparam logic [AXI4_ADDR_BITS-1:0] ADDR_DATA = BASE_ADDR;
    localparam logic [AXI4_ADDR_BITS-1:0] ADDR_STAT = BASE_ADDR + AXI4_ADDR_BITS'(8);
    localparam logic [AXI4_ADDR_BITS-1:0] ADDR_CTRL = BASE_ADDR + AXI4_ADDR_BITS'(16);
    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_POLL_REQ, S_POLL_RESP,
        S_GAP, S_RD_REQ, S_RD_RESP, S_PUSH, S_ERR
    } state_t;

    state_t state, state_nxt, wret, wret_nxt;
    logic [1:0] wval, wval_nxt;
    logic wchain, wchain_nxt, flushing, flushing_nxt, stop_pend, stop_pend_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic err_nxt, ovf_nxt, busy_nxt, out_valid_nxt;
    logic [AXI4_DATA_BITS-1:0] out_data_nxt, w_data_nxt;
    logic [31:0] word_cnt_nxt;
    logic aw_valid_nxt, w_valid_nxt, b_ready_nxt, ar_valid_nxt, r_ready_nxt;
    logic [AXI4_ADDR_BITS-1:0] aw_addr_nxt, ar_addr_nxt;
    logic in_busy;

    assign in_busy            = (state != S_IDLE) && (state != S_ERR);
    assign m_axi4lite_aw_prot = '0;
    assign m_axi4lite_ar_prot = '0;
    assign m_axi4lite_w_strb  = '1;

    always_ff @(posedge m_axi4lite_clk) begin
        if (!m_axi4lite_rstn) begin
            state               <= S_IDLE;
            wret                <= S_IDLE;
            wval                <= 2'b00;
            wchain              <= 1'b0;
            flushing            <= 1'b0;
            stop_pend           <= 1'b0;
            gap_cnt             <= '0;
            err                 <= 1'b0;
            overflow            <= 1'b0;
            busy                <= 1'b0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            word_cnt            <= '0;
            m_axi4lite_aw_valid <= 1'b0;
            m_axi4lite_aw_addr  <= '0;
            m_axi4lite_w_valid  <= 1'b0;
            m_axi4lite_w_data   <= '0;
            m_axi4lite_b_ready  <= 1'b0;
            m_axi4lite_ar_valid <= 1'b0;
            m_axi4lite_ar_addr  <= '0;
            m_axi4lite_r_ready  <= 1'b0;
        end else begin
            state               <= state_nxt;
            wret                <= wret_nxt;
            wval                <= wval_nxt;
            wchain              <= wchain_nxt;
            flushing            <= flushing_nxt;
            stop_pend           <= stop_pend_nxt;
            gap_cnt             <= gap_nxt;
            err                 <= err_nxt;
            overflow            <= ovf_nxt;
            busy                <= busy_nxt;
            out_valid           <= out_valid_nxt;
            out_data            <= out_data_nxt;
            word_cnt            <= word_cnt_nxt;
            m_axi4lite_aw_valid <= aw_valid_nxt;
            m_axi4lite_aw_addr  <= aw_addr_nxt;
            m_axi4lite_w_valid  <= w_valid_nxt;
            m_axi4lite_w_data   <= w_data_nxt;
            m_axi4lite_b_ready  <= b_ready_nxt;
            m_axi4lite_ar_valid <= ar_valid_nxt;
            m_axi4lite_ar_addr  <= ar_addr_nxt;
            m_axi4lite_r_ready  <= r_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wret_nxt      = wret;
        wval_nxt      = wval;
        wchain_nxt    = wchain;
        flushing_nxt  = flushing;
        stop_pend_nxt = stop_pend | (stop & in_busy);
        gap_nxt       = gap_cnt;
        err_nxt       = err;
        ovf_nxt       = overflow;
        out_data_nxt  = out_data;
        word_cnt_nxt  = word_cnt;
        aw_addr_nxt   = m_axi4lite_aw_addr;
        w_data_nxt    = m_axi4lite_w_data;
        ar_addr_nxt   = m_axi4lite_ar_addr;
        aw_valid_nxt  = m_axi4lite_aw_valid & ~m_axi4lite_aw_ready;
        w_valid_nxt   = m_axi4lite_w_valid & ~m_axi4lite_w_ready;

        case (state)
            S_IDLE, S_ERR: begin
                if (flush && state == S_IDLE) begin
                    wval_nxt     = 2'b01;
                    wret_nxt     = S_IDLE;
                    wchain_nxt   = 1'b1;
                    flushing_nxt = 1'b1;
                    state_nxt    = S_WR_REQ;
                end else if (start) begin
                    wval_nxt     = 2'b11;
                    wret_nxt     = S_POLL_REQ;
                    wchain_nxt   = 1'b0;
                    flushing_nxt = 1'b0;
                    state_nxt    = S_WR_REQ;
                    if (state == S_ERR) begin
                        err_nxt = 1'b0;
                        ovf_nxt = 1'b0;
                    end
                end
            end
            S_WR_REQ: begin
                if ((!m_axi4lite_aw_valid || m_axi4lite_aw_ready) &&
                    (!m_axi4lite_w_valid || m_axi4lite_w_ready))
                    state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axi4lite_b_valid) begin
                    if (m_axi4lite_b_resp != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_ERR;
                    end else if (wchain) begin
                        // Second half of a flush: release user reset, capture stays off
                        wval_nxt   = 2'b10;
                        wchain_nxt = 1'b0;
                        state_nxt  = S_WR_REQ;
                    end else begin
                        if (flushing) begin
                            ovf_nxt      = 1'b0;
                            flushing_nxt = 1'b0;
                        end
                        state_nxt = wret;
                    end
                end
            end
            S_POLL_REQ, S_RD_REQ: begin
                if (m_axi4lite_ar_ready)
                    state_nxt = (state == S_POLL_REQ) ? S_POLL_RESP : S_RD_RESP;
            end
            S_POLL_RESP: begin
                if (m_axi4lite_r_valid) begin
                    if (m_axi4lite_r_resp != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        if (m_axi4lite_r_data[1])
                            ovf_nxt = 1'b1;
                        state_nxt = m_axi4lite_r_data[0] ? S_GAP : S_RD_REQ;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == 16'd0)
                    state_nxt = S_POLL_REQ;
                else
                    gap_nxt = gap_cnt - 16'd1;
            end
            S_RD_RESP: begin
                if (m_axi4lite_r_valid) begin
                    if (m_axi4lite_r_resp != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        out_data_nxt = m_axi4lite_r_data;
                        state_nxt    = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    word_cnt_nxt = word_cnt + 32'd1;
                    state_nxt    = S_POLL_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A pending stop only diverts transitions between transactions
        if (state_nxt != state && (state_nxt == S_POLL_REQ || state_nxt == S_GAP) &&
            (stop_pend || stop)) begin
            wval_nxt      = 2'b10;
            wret_nxt      = S_IDLE;
            wchain_nxt    = 1'b0;
            stop_pend_nxt = 1'b0;
            state_nxt     = S_WR_REQ;
        end
        if (state_nxt == S_IDLE || state_nxt == S_ERR)
            stop_pend_nxt = 1'b0;

        if (state_nxt != state) begin
            case (state_nxt)
                S_WR_REQ: begin
                    aw_valid_nxt = 1'b1;
                    w_valid_nxt  = 1'b1;
                    aw_addr_nxt  = ADDR_CTRL;
                    w_data_nxt   = AXI4_DATA_BITS'(wval_nxt);
                end
                S_POLL_REQ: ar_addr_nxt = ADDR_STAT;
                S_RD_REQ:   ar_addr_nxt = ADDR_DATA;
                S_GAP:      gap_nxt = GAP_LOAD;
                default: ;
            endcase
        end

        ar_valid_nxt  = (state_nxt == S_POLL_REQ) || (state_nxt == S_RD_REQ);
        r_ready_nxt   = (state_nxt == S_POLL_RESP) || (state_nxt == S_RD_RESP);
        b_ready_nxt   = (state_nxt == S_WR_RESP);
        out_valid_nxt = (state_nxt == S_PUSH);
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
    end
endmodule

// File: tb/tb_sipo_drain_ctrl.sv
// tb/tb_sipo_drain_ctrl.sv - scoreboard bench for sipo_drain_ctrl against a behavioural sipo slave
module tb_sipo_drain_ctrl;
    localparam int G = 6;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0, flush = 1'b0;
    logic out_valid, out_ready = 1'b0, busy, err, overflow;
    logic [31:0] out_data, word_cnt;
    logic aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0, b_valid = 1'b0, b_ready;
    logic ar_valid, ar_ready = 1'b0, r_valid = 1'b0, r_ready;
    logic [31:0] aw_addr, w_data, ar_addr, r_data = '0;
    logic [2:0] aw_prot, ar_prot;
    logic [3:0] w_strb;
    logic [1:0] b_resp = 2'b00, r_resp = 2'b00;

    sipo_drain_ctrl #(.POLL_GAP(G)) dut (
        .m_axi4lite_clk(clk), .m_axi4lite_rstn(rstn),
        .start(start), .stop(stop), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .err(err), .overflow(overflow), .word_cnt(word_cnt),
        .m_axi4lite_aw_valid(aw_valid), .m_axi4lite_aw_ready(aw_ready),
        .m_axi4lite_aw_addr(aw_addr), .m_axi4lite_aw_prot(aw_prot),
        .m_axi4lite_w_valid(w_valid), .m_axi4lite_w_ready(w_ready),
        .m_axi4lite_w_data(w_data), .m_axi4lite_w_strb(w_strb),
        .m_axi4lite_b_valid(b_valid), .m_axi4lite_b_ready(b_ready), .m_axi4lite_b_resp(b_resp),
        .m_axi4lite_ar_valid(ar_valid), .m_axi4lite_ar_ready(ar_ready),
        .m_axi4lite_ar_addr(ar_addr), .m_axi4lite_ar_prot(ar_prot),
        .m_axi4lite_r_valid(r_valid), .m_axi4lite_r_ready(r_ready),
        .m_axi4lite_r_data(r_data), .m_axi4lite_r_resp(r_resp)
    );

    int total = 0, bad = 0, delivered = 0, ar_count = 0;
    int unsigned cyc = 0;
    logic [31:0] fifo[$], exp_q[$], exp_ctrl[$];
    int unsigned stimes[$], dtimes[$];
    bit rand_rdy = 0, aw_hold = 0, slverr_data = 0, rand_rdelay = 0;
    int r_delay = 0, out_mode = 0;
    bit aw_got, w_got, b_pend, b_hs, r_hs, stall;
    int rd_kind, rd_wait;
    logic [31:0] wd, held;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic load(input logic [31:0] w);
        fifo.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) start = 1'b1; else if (which == 1) stop = 1'b1; else flush = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        fifo.delete(); exp_q.delete(); exp_ctrl.delete();
        delivered = 0;
        @(negedge clk);
        check("rst_valids", 32'({aw_valid, w_valid, ar_valid, b_ready, r_ready, out_valid}), 0);
        check("rst_flags", 32'({busy, err, overflow}), 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_addr", aw_addr | ar_addr | w_data, 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // sipo slave model: readies chosen first, then handshakes seen at the next posedge are logged
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
            aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_hs = 0; rd_kind = 0;
            continue;
        end
        if (b_hs) b_valid = 1'b0;
        if (b_pend) begin b_valid = 1'b1; b_resp = 2'b00; b_pend = 1'b0; end
        if (r_hs) r_valid = 1'b0;
        if (rd_kind != 0 && !r_valid) begin
            if (rd_wait > 0) rd_wait--;
            else begin
                r_valid = 1'b1; r_resp = 2'b00;
                if (rd_kind == 1) r_data = {30'd0, fifo.size() >= 4, fifo.size() == 0};
                else if (slverr_data) begin r_resp = 2'b10; r_data = '0; slverr_data = 0; end
                else begin
                    check("data_read_nonempty", 32'(fifo.size() != 0), 1);
                    r_data = (fifo.size() != 0) ? fifo.pop_front() : 32'd0;
                end
                rd_kind = 0;
            end
        end
        aw_ready = aw_hold ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
        w_ready  = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        ar_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        if (aw_valid && aw_ready) begin aw_got = 1; check("aw_addr", aw_addr, 32'h10); end
        if (w_valid && w_ready) begin w_got = 1; wd = w_data; check("w_strb", 32'(w_strb), 32'hF); end
        if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; b_pend = 1;
            if (exp_ctrl.size() == 0) begin
                total++; bad++;
                $display("FAIL ctrl_write_unexpected: got 0x%0h with no write pending", wd);
            end else check("ctrl_wdata", wd, exp_ctrl.pop_front());
            if (!wd[1]) begin
                repeat (fifo.size()) void'(exp_q.pop_back());
                fifo.delete();
            end
        end
        if (ar_valid && ar_ready) begin
            check("ar_addr_legal", 32'(ar_addr == 32'h0 || ar_addr == 32'h8), 1);
            ar_count++;
            rd_kind = (ar_addr == 32'h8) ? 1 : 2;
            if (rd_kind == 1) stimes.push_back(cyc); else dtimes.push_back(cyc);
            rd_wait = rand_rdelay ? int'($urandom_range(3)) : r_delay;
        end
        b_hs = b_valid && b_ready;
        r_hs = r_valid && r_ready;
    end

    // stream monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (!rstn) begin stall = 0; out_ready = 1'b0; continue; end
        case (out_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
        if (stall && out_valid) check("out_data_stable", out_data, held);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stream_extra: got 0x%0h with empty scoreboard", out_data);
            end else begin
                check("stream_word", out_data, exp_q.pop_front());
                check("word_cnt", word_cnt, delivered);
                delivered++;
            end
            stall = 0;
        end else begin
            stall = out_valid;
            held = out_data;
        end
    end

    initial begin
        int d0, n_ar, i;
        do_reset();

        // three words, full-rate drain, then idle polling cadence
        dtimes.delete();
        load(32'hA1); load(32'hB2); load(32'hC3);
        exp_ctrl.push_back(32'h3);
        pulse(0);
        for (i = 0; i < 300 && delivered < 3; i++) @(negedge clk);
        check("t1_delivered", delivered, 3);
        stimes.delete();
        @(negedge clk);
        check("t1_word_cnt", word_cnt, 3);
        check("t1_ctrl_done", exp_ctrl.size(), 0);
        check("t1_data_reads", dtimes.size(), 3);
        if (dtimes.size() >= 3) begin
            check("t1_cadence_a", dtimes[1] - dtimes[0], 5);
            check("t1_cadence_b", dtimes[2] - dtimes[1], 5);
        end
        repeat (4 * (G + 2) + 4) @(negedge clk);
        check("t1_polls_seen", 32'(stimes.size() >= 4), 1);
        for (int k = 1; k < stimes.size(); k++) check("t1_poll_gap", stimes[k] - stimes[k-1], G + 2);

        // back-pressure in PUSH
        out_mode = 1;
        load(32'h5A);
        for (i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check("t2_push_seen", 32'(out_valid), 1);
        n_ar = ar_count;
        d0 = delivered;
        repeat (20) begin
            @(negedge clk);
            check("t2_hold_data", out_data, 32'h5A);
            check("t2_no_ar", 32'(ar_valid), 0);
        end
        check("t2_ar_count", ar_count, n_ar);
        out_mode = 0;
        repeat (10) @(negedge clk);
        check("t2_once", delivered, d0 + 1);

        // stop during a slow data read
        r_delay = 5;
        d0 = delivered;
        n_ar = dtimes.size();
        load(32'h77);
        for (i = 0; i < 400 && dtimes.size() == n_ar; i++) @(negedge clk);
        check("t3_read_issued", 32'(dtimes.size() > n_ar), 1);
        exp_ctrl.push_back(32'h2);
        pulse(1);
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        check("t3_idle", 32'(busy), 0);
        check("t3_pushed", delivered, d0 + 1);
        check("t3_ctrl_done", exp_ctrl.size(), 0);
        r_delay = 0;

        // overflow observed, then flush
        d0 = delivered;
        load(32'hA0); load(32'hA1); load(32'hA2); load(32'hA3);
        exp_ctrl.push_back(32'h3);
        pulse(0);
        for (i = 0; i < 300 && delivered < d0 + 4; i++) @(negedge clk);
        check("t4_delivered", delivered, d0 + 4);
        check("t4_overflow_set", 32'(overflow), 1);
        exp_ctrl.push_back(32'h2);
        pulse(1);
        for (i = 0; i < 200 && busy; i++) @(negedge clk);
        check("t4_stopped", 32'(busy), 0);
        check("t4_overflow_sticky", 32'(overflow), 1);
        exp_ctrl.push_back(32'h1); exp_ctrl.push_back(32'h2);
        pulse(2);
        for (i = 0; i < 100 && (busy || exp_ctrl.size() != 0); i++) @(negedge clk);
        check("t4_flush_writes", exp_ctrl.size(), 0);
        check("t4_overflow_clear", 32'(overflow), 0);

        // SLVERR on a data read
        d0 = delivered;
        slverr_data = 1;
        load(32'h99);
        exp_ctrl.push_back(32'h3);
        pulse(0);
        for (i = 0; i < 200 && !err; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_err", 32'(err), 1);
        check("t5_busy", 32'(busy), 0);
        check("t5_no_stream", delivered, d0);
        check("t5_no_valid", 32'({out_valid, ar_valid, aw_valid, w_valid}), 0);
        exp_ctrl.push_back(32'h3);
        pulse(0);
        for (i = 0; i < 200 && delivered == d0; i++) @(negedge clk);
        check("t5_err_cleared", 32'(err), 0);
        check("t5_recovered", delivered, d0 + 1);
        check("t5_rewrite", exp_ctrl.size(), 0);
        exp_ctrl.push_back(32'h2);
        pulse(1);
        for (i = 0; i < 200 && busy; i++) @(negedge clk);

        // reset while AW is stalled
        aw_hold = 1;
        exp_ctrl.push_back(32'h3);
        pulse(0);
        for (i = 0; i < 20 && !aw_valid; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_aw_held", 32'(aw_valid), 1);
        do_reset();
        aw_hold = 0;

        // randomized traffic against the scoreboard
        rand_rdy = 1; rand_rdelay = 1; out_mode = 2;
        exp_ctrl.push_back(32'h3);
        pulse(0);
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(5) == 0 && fifo.size() < 4) load($urandom);
        end
        for (i = 0; i < 600 && (fifo.size() != 0 || exp_q.size() != 0); i++) @(negedge clk);
        check("rnd_drained", exp_q.size(), 0);
        exp_ctrl.push_back(32'h2);
        pulse(1);
        for (i = 0; i < 400 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("rnd_idle", 32'(busy), 0);
        check("rnd_ctrl_done", exp_ctrl.size(), 0);
        check("rnd_word_cnt", word_cnt, delivered);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
